// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions: read-FSM states, RS codes, busy-flag bit and the
// default bus timing also used by LCD_Display.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EHIGH = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } lcd_state_e;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  localparam int BF_BIT = 7;

  // 50 MHz clock: one complete E cycle is 31 clocks = 620 ns
  localparam int LCD_T_AS     = 3;
  localparam int LCD_T_EH     = 16;
  localparam int LCD_T_AH     = 2;
  localparam int LCD_T_GAP    = 10;
  localparam int LCD_POLL_MAX = 4095;

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Request/response and LCD pin bundle of the read-side LCD controller.
interface lcd_bus_reader_if;

  logic       iREQ;
  logic       iRS;
  logic       iPOLL;
  logic [7:0] oDATA;
  logic       oDONE;
  logic       oBUSY;
  logic       oTIMEOUT;
  logic       oBUS_OWN;
  logic       LCD_RW;
  logic       LCD_E;
  logic       LCD_RS;
  wire  [7:0] DATA_BUS;

  modport master (
    output iREQ, iRS, iPOLL,
    input  oDATA, oDONE, oBUSY, oTIMEOUT, oBUS_OWN, LCD_RW, LCD_E, LCD_RS,
    inout  DATA_BUS
  );

  modport slave (
    input  iREQ, iRS, iPOLL,
    output oDATA, oDONE, oBUSY, oTIMEOUT, oBUS_OWN, LCD_RW, LCD_E, LCD_RS,
    inout  DATA_BUS
  );

endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable 16-bit down-counter reused for every bus phase; zero pulses for one
// cycle on the last cycle of a loaded count (load value N-1 gives N cycles).
module lcd_phase_timer (
  input  logic        clk_sys,
  input  logic        rst_b,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] cnt_q;
  logic        armed_q;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (load) begin
      cnt_q   <= load_val;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (cnt_q == 16'd0) armed_q <= 1'b0;
      else                cnt_q   <= cnt_q - 16'd1;
    end
  end

  assign zero = armed_q && (cnt_q == 16'd0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle controller (busy-flag/AC or data reads, optional BF polling).
// Define LCD_POLL_TIMEOUT_EN to bound polling at POLL_MAX read cycles.
//
// state | meaning
// IDLE  | waiting for iREQ; oDONE cycle of the previous read
// SETUP | RW=1, RS valid, E low (address setup)
// EHIGH | E high; DATA_BUS sampled on the last cycle
// HOLD  | E low, RW/RS still held
// GAP   | RW/RS released, bus still owned; decides re-poll or completion
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS     = LCD_T_AS,
  parameter int T_EH     = LCD_T_EH,
  parameter int T_AH     = LCD_T_AH,
  parameter int T_GAP    = LCD_T_GAP,
  parameter int POLL_MAX = LCD_POLL_MAX
) (
  input logic             iCLK_50MHZ,
  input logic             iRST_N,
  lcd_bus_reader_if.slave bus
);

  if (T_AS < 1 || T_EH < 1 || T_AH < 1 || T_GAP < 1 || POLL_MAX < 1) begin : g_bad_param
    $error("lcd_bus_reader: timing and poll parameters must be at least 1");
  end

  lcd_state_e  state_q, state_d;
  logic        rs_q, rs_d, poll_q;
  logic [7:0]  sample_q, data_q;
  logic        e_q, rw_q, rs_pin_q, done_q, busy_q;
  logic        tmr_load, tmr_zero;
  logic [15:0] tmr_val;
  logic        accept, done_d, rw_d, bf_set, poll_limit;

  lcd_phase_timer u_timer (
    .clk_sys  (iCLK_50MHZ),
    .rst_b    (iRST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign bf_set = sample_q[BF_BIT];

`ifdef LCD_POLL_TIMEOUT_EN
  logic [15:0] poll_cnt_q;
  logic        tmo_q;

  assign poll_limit = (poll_cnt_q == 16'(POLL_MAX - 1));

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      poll_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      tmo_q <= done_d && poll_q && bf_set;
      if (accept)
        poll_cnt_q <= '0;
      else if (state_q == GAP && tmr_zero && state_d == SETUP)
        poll_cnt_q <= poll_cnt_q + 16'd1;
    end
  end

  assign bus.oTIMEOUT = tmo_q;
`else
  assign poll_limit   = 1'b0;
  assign bus.oTIMEOUT = 1'b0;
`endif

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    accept   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iREQ) begin
          accept   = 1'b1;
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = 16'(T_AS - 1);
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_d  = EHIGH;
          tmr_load = 1'b1;
          tmr_val  = 16'(T_EH - 1);
        end
      end
      EHIGH: begin
        if (tmr_zero) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = 16'(T_AH - 1);
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = 16'(T_GAP - 1);
        end
      end
      GAP: begin
        if (tmr_zero) begin
          if (poll_q && bf_set && !poll_limit) begin
            state_d  = SETUP;
            tmr_load = 1'b1;
            tmr_val  = 16'(T_AS - 1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rs_d = accept ? bus.iRS : rs_q;
  assign rw_d = (state_d == SETUP) || (state_d == EHIGH) || (state_d == HOLD);

  // Pins are registered from the next state so they change cleanly with the FSM.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      rs_q     <= 1'b0;
      poll_q   <= 1'b0;
      sample_q <= '0;
      data_q   <= '0;
      e_q      <= 1'b0;
      rw_q     <= 1'b0;
      rs_pin_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (accept) begin
        rs_q   <= bus.iRS;
        poll_q <= bus.iPOLL && (bus.iRS == LCD_RS_CMD);
      end
      if (state_q == EHIGH && tmr_zero) sample_q <= bus.DATA_BUS;
      if (done_d) data_q <= sample_q;
      e_q      <= (state_d == EHIGH);
      rw_q     <= rw_d;
      rs_pin_q <= rw_d && rs_d;
      done_q   <= done_d;
      busy_q   <= (state_d != IDLE) || done_d;
    end
  end

  // The reader only listens: DATA_BUS is never driven from this side.
  assign bus.oDATA    = data_q;
  assign bus.oDONE    = done_q;
  assign bus.oBUSY    = busy_q;
  assign bus.oBUS_OWN = busy_q;
  assign bus.LCD_E    = e_q;
  assign bus.LCD_RW   = rw_q;
  assign bus.LCD_RS   = rs_pin_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: LCD bus model, expected-result queue,
// latency/pulse-shape checks, reset abort and request handling.
module tb_lcd_bus_reader;

  typedef struct {
    logic [7:0] data;
    logic       tmo;
    int         lat;
    int         pulses;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  lcd_bus_reader_if bus ();

  lcd_bus_reader #(.POLL_MAX(4)) dut (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .bus        (bus)
  );

  exp_t       sb[$];
  int         e_rise[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         e_pulses = 0;
  logic       e_prev   = 1'b0;
  int         busy_until = 0;
  logic [7:0] busy_val   = 8'h00;
  logic [7:0] final_val  = 8'h00;
  logic [7:0] lcd_dq;
  int         base, pulse_base, rise_base;
  int         last_ehi, last_rshi;
  bit         hold_req = 1'b0;

  // LCD model: the first busy_until pulses return busy_val, later ones final_val
  assign lcd_dq       = (e_pulses <= busy_until) ? busy_val : final_val;
  assign bus.DATA_BUS = lcd_dq;

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.LCD_E === 1'b1 && !e_prev) begin
      e_pulses++;
      e_rise.push_back(cyc);
    end
    e_prev = bus.LCD_E;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rs, input logic poll, input int nb,
                       input logic [7:0] bv, input logic [7:0] fv,
                       input logic [7:0] exp_data, input logic exp_tmo,
                       input int exp_lat, input int exp_pulses);
    sb.push_back('{data: exp_data, tmo: exp_tmo, lat: exp_lat, pulses: exp_pulses});
    busy_until = e_pulses + nb;
    busy_val   = bv;
    final_val  = fv;
    pulse_base = e_pulses;
    rise_base  = e_rise.size();
    bus.iRS    = rs;
    bus.iPOLL  = poll;
    bus.iREQ   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_req) bus.iREQ = 1'b0;
    base = cyc;
    chk("busy_after_accept", bus.oBUSY, 1);
  endtask

  task automatic finish_read(input string tag, input int poke, input int limit);
    bit         got = 1'b0;
    bit         moved = 1'b0;
    int         c = 0;
    int         ehi = 0;
    int         rshi = 0;
    logic [7:0] prev;
    exp_t       e;
    prev = bus.oDATA;
    for (int k = 0; k < limit; k++) begin
      c = cyc - base + 1;
      if (bus.oDONE === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (bus.LCD_E === 1'b1) ehi++;
      if (bus.LCD_RS === 1'b1 && bus.LCD_RW === 1'b1) rshi++;
      if (bus.oDATA !== prev) moved = 1'b1;
      if (poke > 0 && c == poke) bus.iREQ = 1'b1;
      else if (!hold_req)        bus.iREQ = 1'b0;
      @(negedge clk);
    end
    last_ehi  = ehi;
    last_rshi = rshi;
    chk({tag, "_done_seen"}, got, 1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, bus.oDATA, e.data);
      chk({tag, "_timeout"}, bus.oTIMEOUT, e.tmo);
      chk({tag, "_latency"}, c, e.lat);
      chk({tag, "_pulses"}, e_pulses - pulse_base, e.pulses);
      chk({tag, "_odata_held"}, moved, 0);
      chk({tag, "_busy_in_done"}, bus.oBUSY, 1);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_busy_low"}, bus.oBUSY, 0);
    chk({tag, "_own_low"}, bus.oBUS_OWN, 0);
    chk({tag, "_done_pulse"}, bus.oDONE, 0);
    chk({tag, "_tmo_pulse"}, bus.oTIMEOUT, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_e"}, bus.LCD_E, 0);
    chk({tag, "_rw"}, bus.LCD_RW, 0);
    chk({tag, "_rs"}, bus.LCD_RS, 0);
    chk({tag, "_data"}, bus.oDATA, 0);
    chk({tag, "_done"}, bus.oDONE, 0);
    chk({tag, "_busy"}, bus.oBUSY, 0);
    chk({tag, "_own"}, bus.oBUS_OWN, 0);
    chk({tag, "_tmo"}, bus.oTIMEOUT, 0);
  endtask

  initial begin
    int extra_done;
    rst_n     = 1'b0;
    bus.iREQ  = 1'b0;
    bus.iRS   = 1'b0;
    bus.iPOLL = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single data read
    issue(1'b1, 1'b0, 0, 8'h00, 8'hA5, 8'hA5, 1'b0, 32, 1);
    finish_read("data_rd", 0, 200);
    chk("data_rd_e_high", last_ehi, 16);
    chk("data_rd_rs_rw", last_rshi, 21);
    idle_check("data_rd");

    // reset in the middle of a read aborts it
    issue(1'b1, 1'b0, 0, 8'h00, 8'h3C, 8'h3C, 1'b0, 32, 1);
    void'(sb.pop_back());
    repeat (7) @(negedge clk);
    chk("abort_e_before_reset", bus.LCD_E, 1);
    #3 rst_n = 1'b0;
    #1 check_all_zero("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    extra_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.oDONE === 1'b1) extra_done++;
    end
    chk("abort_no_done", extra_done, 0);
    chk("abort_odata", bus.oDATA, 0);

    // single busy-flag read
    issue(1'b0, 1'b0, 0, 8'h00, 8'h8C, 8'h8C, 1'b0, 32, 1);
    finish_read("bf_rd", 0, 200);
    chk("bf_rd_rs_rw", last_rshi, 0);
    idle_check("bf_rd");

    // iPOLL is ignored on data reads even with bit7 set
    issue(1'b1, 1'b1, 0, 8'h00, 8'h80, 8'h80, 1'b0, 32, 1);
    finish_read("poll_data", 0, 200);
    idle_check("poll_data");

    // busy-flag poll: three busy samples, then clear
    issue(1'b0, 1'b1, 3, 8'h85, 8'h05, 8'h05, 1'b0, 125, 4);
    finish_read("poll", 0, 400);
    if (e_rise.size() >= rise_base + 4)
      for (int i = 1; i < 4; i++)
        chk("poll_spacing", e_rise[rise_base + i] - e_rise[rise_base + i - 1], 31);
    else
      chk("poll_rise_count", e_rise.size() - rise_base, 4);
    idle_check("poll");

    // request while busy is dropped
    issue(1'b1, 1'b0, 0, 8'h00, 8'h3E, 8'h3E, 1'b0, 32, 1);
    finish_read("poke", 10, 200);
    idle_check("poke");
    extra_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.oDONE === 1'b1) extra_done++;
    end
    chk("poke_single_done", extra_done, 0);

    // held request: re-accepted right out of the oDONE/IDLE cycle
    hold_req = 1'b1;
    issue(1'b1, 1'b0, 0, 8'h00, 8'h5A, 8'h5A, 1'b0, 32, 1);
    finish_read("held1", 0, 200);
    sb.push_back('{data: 8'h96, tmo: 1'b0, lat: 32, pulses: 1});
    busy_until = e_pulses;
    final_val  = 8'h96;
    pulse_base = e_pulses;
    @(negedge clk);
    bus.iREQ = 1'b0;
    hold_req = 1'b0;
    base     = cyc;
    chk("held2_busy", bus.oBUSY, 1);
    chk("held2_rw_setup", bus.LCD_RW, 1);
    chk("held2_e_low", bus.LCD_E, 0);
    finish_read("held2", 0, 200);
    idle_check("held2");

`ifdef LCD_POLL_TIMEOUT_EN
    // BF stuck high: gives up after POLL_MAX (4) read cycles
    issue(1'b0, 1'b1, 1000, 8'h80, 8'h00, 8'h80, 1'b1, 125, 4);
    finish_read("timeout", 0, 400);
    idle_check("timeout");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
